// File: rtl/execute_mdu.sv
`default_nettype none
// ============================================================================
// Module   : execute_mdu
// Brief    : Execute-stage multiply/divide unit owning HI/LO, with a
//            countdown counter that models multi-cycle MULT/DIV latency.
// Revision : 1.0 - initial release
// ============================================================================
module execute_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] result
);

    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;
    localparam logic [2:0] c_OP_MFHI = 3'd6;
    localparam logic [2:0] c_OP_MFLO = 3'd7;

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;

    logic               w_start;
    logic               w_is_div;
    logic               w_is_unsigned;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_divisor;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_qu;
    logic [31:0]        w_ru;
    logic [31:0]        w_qs_mag;
    logic [31:0]        w_rs_mag;
    logic [31:0]        w_qs;
    logic [31:0]        w_rs;
    logic [31:0]        w_calc_hi;
    logic [31:0]        w_calc_lo;

    assign w_start       = en & ~r_busy & ~ctrl[2];
    assign w_is_div      = ctrl[1];
    assign w_is_unsigned = ctrl[0];

    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Zero divisor is replaced to keep the divider defined; its result is discarded anyway.
    assign w_divisor = (b == 32'd0) ? 32'd1 : b;
    assign w_qu      = a / w_divisor;
    assign w_ru      = a % w_divisor;

    // Signed divide through magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
    assign w_a_mag  = a[31] ? (32'd0 - a) : a;
    assign w_b_mag  = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
    assign w_qs_mag = w_a_mag / w_b_mag;
    assign w_rs_mag = w_a_mag % w_b_mag;
    assign w_qs     = (a[31] ^ w_divisor[31]) ? (32'd0 - w_qs_mag) : w_qs_mag;
    assign w_rs     = a[31] ? (32'd0 - w_rs_mag) : w_rs_mag;

    always_comb begin
        w_calc_hi = r_hi;
        w_calc_lo = r_lo;
        if (!w_is_div) begin
            w_calc_hi = w_is_unsigned ? w_prod_u[63:32] : w_prod_s[63:32];
            w_calc_lo = w_is_unsigned ? w_prod_u[31:0]  : w_prod_s[31:0];
        end else if (b != 32'd0) begin
            w_calc_hi = w_is_unsigned ? w_ru : w_rs;
            w_calc_lo = w_is_unsigned ? w_qu : w_qs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else if (w_start) begin
            r_pend_hi <= w_calc_hi;
            r_pend_lo <= w_calc_lo;
            r_count   <= w_is_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            if (r_count == c_CNT_W'(1)) begin
                r_hi    <= r_pend_hi;
                r_lo    <= r_pend_lo;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end else if (en && ctrl == c_OP_MTHI) begin
            r_hi <= a;
        end else if (en && ctrl == c_OP_MTLO) begin
            r_lo <= a;
        end
    end

    always_comb begin
        result = 32'd0;
        if (en && ctrl == c_OP_MFHI) begin
            result = r_hi;
        end else if (en && ctrl == c_OP_MFLO) begin
            result = r_lo;
        end
    end

    assign start = w_start;
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_execute_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_mdu
// Brief    : Directed self-checking bench for execute_mdu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_mdu;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    execute_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .ctrl   (ctrl),
        .a      (a),
        .b      (b),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] c, input logic [31:0] va, input logic [31:0] vb);
        en = e; ctrl = c; a = va; b = vb;
        #1;
    endtask

    // Issues a mult/div, holds MFLO during the busy window and checks the commit.
    task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] va,
                         input logic [31:0] vb, input int n,
                         input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] old_lo;
        old_lo = lo;
        drive(1'b1, c, va, vb);
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        tick();
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 3'd7, 32'd0, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_mflo_old"}, result, old_lo);
            chk({tag, "_nostart"}, {31'd0, start}, 32'd0);
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_result", result, 32'd0);

        do_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        do_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu",  3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);

        // Load HI/LO, then divide by zero leaves them unchanged.
        tick();
        drive(1'b1, 3'd4, 32'h11, 32'd0);
        tick();
        drive(1'b1, 3'd5, 32'h22, 32'd0);
        tick();
        do_op("div0",  3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        do_op("divov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // MTHI then MFHI in the very next cycle.
        tick();
        drive(1'b1, 3'd4, 32'h1234_5678, 32'd0);
        tick();
        drive(1'b1, 3'd6, 32'd0, 32'd0);
        chk("mfhi_fwd", result, 32'h1234_5678);
        tick();

        // MTLO and MULT issued while busy are both dropped.
        drive(1'b1, 3'd0, 32'd2, 32'd3);
        chk("ign_start", {31'd0, start}, 32'd1);
        tick();
        drive(1'b1, 3'd5, 32'hDEAD, 32'd0);
        chk("ign_mtlo_busy", {31'd0, busy}, 32'd1);
        tick();
        drive(1'b1, 3'd0, 32'd7, 32'd7);
        chk("ign_mult_nostart", {31'd0, start}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("ign_lo_mid", lo, 32'h8000_0000);
        tick();
        tick();
        chk("ign_still_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_done", {31'd0, busy}, 32'd0);
        chk("ign_hi", hi, 32'h1234_5678 & 32'd0);
        chk("ign_lo", lo, 32'd6);
        tick();
        chk("ign_no_second", {31'd0, busy}, 32'd0);

        // Reset during busy cycle 3 discards the operation.
        drive(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("rstb_start", {31'd0, start}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rstb_busy3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstb_busy", {31'd0, busy}, 32'd0);
        chk("rstb_hi", hi, 32'd0);
        chk("rstb_lo", lo, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("rstb_late_hi", hi, 32'd0);
        chk("rstb_late_lo", lo, 32'd0);
        chk("rstb_late_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
